mdu_seq: RTL and testbench

//  Iterative multiply/divide unit, the multi-cycle counterpart of the combinational ALU datapath.

---
 rtl/mdu_seq.sv | 86 ++++++++
 tb/tb_mdu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative radix-2 multiply/divide unit, one result bit per cycle
//   i_clk, i_rst (sync, active high); i_req/i_op/i_l/i_r issue an operation, i_kill aborts it
//   o_busy high while iterating, o_valid one-cycle pulse with o_out/o_flags (Z,C,N,O,P)
module mdu_seq #(
  parameter int WIDTH = 16,
  parameter int FLAGS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_l,
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_kill,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_out,
  output logic [FLAGS-1:0] o_flags
);
  localparam int FZ = 0, FC = 1, FN = 2, FO = 3, FP = 4;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic [WIDTH-1:0] l, r, hi, lo, hi_n, lo_n, diff, res;
  logic [WIDTH:0] sum, rem_t;
  logic accept, ge, carry;
  logic [FLAGS-1:0] flg;
  assign accept = i_req & ~i_kill & (st != RUN);
  assign o_busy = st == RUN;
  assign o_valid = st == DONE;
  always_ff @(posedge i_clk)
    st <= i_rst ? IDLE : nxt;
  always_comb begin
    nxt = accept ? RUN : IDLE;
    if (st == RUN) nxt = i_kill ? IDLE : (cnt == '0 ? DONE : RUN);
  end
  // {hi,lo} is the shared iteration register: product {hi,lo} for multiply,
  // {remainder,quotient/dividend} for divide
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, l} : '0);
    rem_t = {hi, lo[WIDTH-1]};
    ge = rem_t >= {1'b0, r};
    // when ge the difference is below r, so the low bits are exact; r==0 keeps
    // shifting the dividend into the remainder, leaving remainder=i_l, quotient=all ones
    diff = rem_t[WIDTH-1:0] - r;
    hi_n = op[1] ? (ge ? diff : rem_t[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = op[1] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    res = op[0] ? hi_n : lo_n;
    carry = op == 2'b00 ? |hi_n : op == 2'b01 ? 1'b0 : ~|r;
    flg = '0;
    flg[FZ] = ~|res;
    flg[FC] = carry;
    flg[FN] = res[WIDTH-1];
    flg[FO] = 1'b0;
    flg[FP] = ^res;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      op <= '0;
      l <= '0;
      r <= '0;
      hi <= '0;
      lo <= '0;
      o_out <= '0;
      o_flags <= '0;
    end else if (accept) begin
      op <= i_op;
      l <= i_l;
      r <= i_r;
      hi <= '0;
      lo <= i_op[1] ? i_l : i_r;
      cnt <= CW'(WIDTH - 1);
    end else if (st == RUN) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0 && !i_kill) begin
        o_out <= res;
        o_flags <= flg;
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed table, random ops against an arithmetic model, and sequence corner cases for mdu_seq
module tb_mdu_seq;
  localparam int W = 16;
  logic i_clk = 0, i_rst = 1, i_req = 0, i_kill = 0;
  logic [1:0] i_op = 0;
  logic [W-1:0] i_l = 0, i_r = 0;
  logic o_busy, o_valid;
  logic [W-1:0] o_out;
  logic [4:0] o_flags;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0] op;
    logic [W-1:0] l, r, out;
    logic [4:0] flags;
  } vec_t;
  vec_t tbl[10];
  always #5 i_clk = ~i_clk;
  mdu_seq #(.WIDTH(W), .FLAGS(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_op(i_op), .i_l(i_l), .i_r(i_r),
    .i_kill(i_kill), .o_busy(o_busy), .o_valid(o_valid), .o_out(o_out), .o_flags(o_flags)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_out(input logic [1:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
    logic [2*W-1:0] p;
    p = {16'd0, l} * {16'd0, r};
    case (op)
      2'd0: return p[W-1:0];
      2'd1: return p[2*W-1:W];
      2'd2: return r == 0 ? 16'hFFFF : l / r;
      default: return r == 0 ? l : l % r;
    endcase
  endfunction
  // flag layout: [0]=Z [1]=C [2]=N [3]=O [4]=P
  function automatic logic [4:0] ref_flags(input logic [1:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
    logic [2*W-1:0] p;
    logic [W-1:0] o;
    logic c;
    p = {16'd0, l} * {16'd0, r};
    o = ref_out(op, l, r);
    c = op == 2'd0 ? (p[2*W-1:W] != 0) : op == 2'd1 ? 1'b0 : (r == 0);
    return {^o, 1'b0, o[W-1], c, o == 0};
  endfunction
  task automatic start(input logic [1:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge i_clk);
    i_req = 1; i_op = op; i_l = l; i_r = r;
    @(negedge i_clk);
    i_req = 0; i_op = ~op; i_l = ~l; i_r = r + 1;
  endtask
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] l,
                       input logic [W-1:0] r, input logic [W-1:0] eo, input logic [4:0] ef);
    int bad;
    bad = 0;
    start(op, l, r);
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge i_clk);
      if (o_busy !== (k <= 16) || o_valid !== (k == 17)) bad++;
    end
    chk({name, " timing"}, bad, 0);
    chk({name, " out"}, o_out, eo);
    chk({name, " flags"}, o_flags, ef);
  endtask
  initial begin
    int bad, n, nv, first;
    logic [1:0] op;
    logic [W-1:0] l, r, po;
    logic [4:0] pf;
    tbl[0] = '{2'd0, 16'h1234, 16'h0010, 16'h2340, 5'b00010};
    tbl[1] = '{2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b10010};
    tbl[2] = '{2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b10100};
    tbl[3] = '{2'd2, 16'd100, 16'd7, 16'h000E, 5'b10000};
    tbl[4] = '{2'd3, 16'd100, 16'd7, 16'h0002, 5'b10000};
    tbl[5] = '{2'd3, 16'd14, 16'd7, 16'h0000, 5'b00001};
    tbl[6] = '{2'd2, 16'h8000, 16'h0000, 16'hFFFF, 5'b00110};
    tbl[7] = '{2'd3, 16'h8000, 16'h0000, 16'h8000, 5'b10110};
    tbl[8] = '{2'd2, 16'hFFFF, 16'h0001, 16'hFFFF, 5'b00100};
    tbl[9] = '{2'd0, 16'h0000, 16'h0005, 16'h0000, 5'b00001};
    repeat (2) @(negedge i_clk);
    chk("reset busy", o_busy, 0);
    chk("reset valid", o_valid, 0);
    chk("reset out", o_out, 0);
    chk("reset flags", o_flags, 0);
    i_rst = 0;
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].l, tbl[i].r, tbl[i].out, tbl[i].flags);
    for (int i = 0; i < 50; i++) begin
      op = 2'($urandom_range(0, 3));
      l = 16'($urandom);
      r = $urandom_range(0, 5) == 0 ? 16'd0 : $urandom_range(0, 1) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      do_op($sformatf("rand%0d op%0d %h %h", i, op, l, r), op, l, r, ref_out(op, l, r), ref_flags(op, l, r));
    end
    // kill in the 5th RUN cycle
    do_op("pre-kill", 2'd0, 16'd3, 16'd5, 16'd15, 5'b00000);
    po = o_out; pf = o_flags;
    start(2'd0, 16'h1234, 16'h0010);
    repeat (4) @(negedge i_clk);
    chk("kill busy before", o_busy, 1);
    i_kill = 1;
    @(negedge i_clk);
    i_kill = 0;
    chk("kill busy after", o_busy, 0);
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_valid || o_busy) bad++;
    end
    chk("kill no valid", bad, 0);
    chk("kill out kept", o_out, po);
    chk("kill flags kept", o_flags, pf);
    // kill in IDLE, and kill together with request
    @(negedge i_clk);
    i_kill = 1; i_req = 1; i_op = 2'd0; i_l = 16'd2; i_r = 16'd2;
    @(negedge i_clk);
    i_kill = 0; i_req = 0;
    chk("kill+req dropped", o_busy, 0);
    @(negedge i_clk);
    chk("kill+req no valid", o_valid, 0);
    chk("kill idle out", o_out, po);
    // reset mid-run
    start(2'd0, 16'h1234, 16'h0010);
    repeat (7) @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0;
    chk("rst mid busy", o_busy, 0);
    chk("rst mid valid", o_valid, 0);
    chk("rst mid out", o_out, 0);
    chk("rst mid flags", o_flags, 0);
    // back-to-back: request held through DONE
    start(2'd0, 16'h1234, 16'h0010);
    repeat (15) @(negedge i_clk);
    i_req = 1; i_op = 2'd2; i_l = 16'd100; i_r = 16'd7;
    @(negedge i_clk);
    chk("b2b first valid", o_valid, 1);
    chk("b2b first out", o_out, 16'h2340);
    @(negedge i_clk);
    i_req = 0;
    chk("b2b accepted", o_busy, 1);
    n = 18;
    while (!o_valid && n < 60) begin
      @(negedge i_clk);
      n++;
    end
    chk("b2b second latency", n, 34);
    chk("b2b second out", o_out, 16'h000E);
    // request pulse while busy is dropped
    start(2'd0, 16'd7, 16'd9);
    @(negedge i_clk);
    i_req = 1; i_op = 2'd0; i_l = 16'd1; i_r = 16'd1;
    @(negedge i_clk);
    i_req = 0;
    nv = 0; first = 0;
    for (int k = 4; k <= 40; k++) begin
      @(negedge i_clk);
      if (o_valid) begin
        nv++;
        if (first == 0) begin
          first = k;
          chk("busy pulse out", o_out, 16'd63);
        end
      end
    end
    chk("busy pulse valid count", nv, 1);
    chk("busy pulse latency", first, 17);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
